// File: rtl/imem_loader_pkg.sv
// Shared widths and FSM state encoding for the instruction-memory loader.
package imem_loader_pkg;

    localparam int unsigned LEN_BYTES      = 2;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned WORD_W         = BYTE_W * BYTES_PER_WORD;
    localparam int unsigned LEN_W          = BYTE_W * LEN_BYTES;
    localparam int unsigned IDX_W          = $clog2(BYTES_PER_WORD);

    typedef logic [2:0] state_t;

    localparam state_t IDLE   = 3'd0;
    localparam state_t LEN_LO = 3'd1;
    localparam state_t LEN_HI = 3'd2;
    localparam state_t DATA   = 3'd3;
    localparam state_t CHECK  = 3'd4;
    localparam state_t DONE   = 3'd5;
    localparam state_t ERROR  = 3'd6;

    // States in which the loader consumes stream bytes.
    function automatic logic is_busy(input state_t s);
        return (s == LEN_LO) || (s == LEN_HI) || (s == DATA) || (s == CHECK);
    endfunction

endpackage

// File: rtl/imem_word_packer.sv
// Packs little-endian stream bytes into 32-bit words; flags the byte that completes a word.
module imem_word_packer
    import imem_loader_pkg::*;
(
    input  logic                SYS_clk,
    input  logic                SYS_reset_n,
    input  logic                clear,
    input  logic                byte_en,
    input  logic [BYTE_W-1:0]   byte_in,
    output logic [WORD_W-1:0]   word_c,
    output logic                word_done_c
);

    localparam int unsigned SH_W = WORD_W - BYTE_W;

    logic [IDX_W-1:0] idx;
    logic [SH_W-1:0]  shreg;

    // Earlier bytes shift down so the first byte of a word lands in [7:0].
    assign word_c      = {byte_in, shreg};
    assign word_done_c = byte_en && (idx == IDX_W'(BYTES_PER_WORD - 1));

    always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
        if (!SYS_reset_n) begin
            idx   <= '0;
            shreg <= '0;
        end else if (clear) begin
            idx   <= '0;
            shreg <= '0;
        end else if (byte_en) begin
            idx   <= idx + IDX_W'(1);
            shreg <= {byte_in, shreg[SH_W-1:BYTE_W]};
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Byte-stream program loader: length header, packed words to imem, core held until done.
// Optional IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte checked in CHECK.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                    SYS_clk,
    input  logic                    SYS_reset_n,
    input  logic                    start,
    input  logic [7:0]              rx_data,
    input  logic                    rx_valid,
    output logic                    rx_ready,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [31:0]             mem_wdata,
    output logic                    cpu_hold,
    output logic                    done,
    output logic                    error,
    output logic [ADDR_WIDTH:0]     word_count
);

    localparam int unsigned CNT_W = ADDR_WIDTH + 1;
    localparam logic [LEN_W:0] MAX_LEN = (LEN_W + 1)'(1) << ADDR_WIDTH;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t PAYLOAD_END = CHECK;
    logic [BYTE_W-1:0] csum_q;
`else
    localparam state_t PAYLOAD_END = DONE;
`endif

    state_t            state;
    state_t            state_nxt;
    logic [BYTE_W-1:0] len_lo;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  len_c;
    logic              hs_c;
    logic              start_ok_c;
    logic              last_word_c;
    logic [WORD_W-1:0] word_c;
    logic              word_done_c;

    assign hs_c        = rx_valid && rx_ready;
    assign start_ok_c  = start && ((state == IDLE) || (state == DONE) || (state == ERROR));
    assign len_c       = {rx_data, len_lo};
    assign last_word_c = (LEN_W'(word_count) + LEN_W'(1)) == len_q;

    imem_word_packer u_packer (
        .SYS_clk     (SYS_clk),
        .SYS_reset_n (SYS_reset_n),
        .clear       (start_ok_c),
        .byte_en     (hs_c && (state == DATA)),
        .byte_in     (rx_data),
        .word_c      (word_c),
        .word_done_c (word_done_c)
    );

    always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
        if (!SYS_reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE, ERROR: begin
                if (start) state_nxt = LEN_LO;
            end
            LEN_LO: begin
                if (hs_c) state_nxt = LEN_HI;
            end
            LEN_HI: begin
                if (hs_c) begin
                    if ({1'b0, len_c} > MAX_LEN) state_nxt = ERROR;
                    else if (len_c == '0)        state_nxt = PAYLOAD_END;
                    else                         state_nxt = DATA;
                end
            end
            DATA: begin
                if (word_done_c && last_word_c) state_nxt = PAYLOAD_END;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHECK: begin
                if (hs_c) state_nxt = (rx_data == csum_q) ? DONE : ERROR;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // Status outputs follow the next state so they change with the state register.
    always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
        if (!SYS_reset_n) begin
            rx_ready   <= 1'b0;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            word_count <= '0;
            len_lo     <= '0;
            len_q      <= '0;
        end else begin
            rx_ready <= is_busy(state_nxt);
            cpu_hold <= (state_nxt != DONE);
            done     <= (state_nxt == DONE);
            error    <= (state_nxt == ERROR);
            mem_we   <= 1'b0;
            if (start_ok_c) word_count <= '0;
            if (hs_c && (state == LEN_LO)) len_lo <= rx_data;
            if (hs_c && (state == LEN_HI)) len_q <= len_c;
            if (word_done_c) begin
                mem_we     <= 1'b1;
                mem_addr   <= word_count[ADDR_WIDTH-1:0];
                mem_wdata  <= word_c;
                word_count <= word_count + CNT_W'(1);
            end
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Running XOR over payload bytes only.
    always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
        if (!SYS_reset_n) begin
            csum_q <= '0;
        end else if (start_ok_c) begin
            csum_q <= '0;
        end else if (hs_c && (state == DATA)) begin
            csum_q <= csum_q ^ rx_data;
        end
    end
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: framing, packing, length limits, gaps, reset mid-load.
module tb_imem_loader;

    localparam int unsigned AW = 10;

    logic          SYS_clk = 1'b0;
    logic          SYS_reset_n = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic          rx_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          cpu_hold;
    logic          done;
    logic          error;
    logic [AW:0]   word_count;

    int checks = 0;
    int errors = 0;

    logic [AW-1:0] wr_addr_q[$];
    logic [31:0]   wr_data_q[$];
    logic [7:0]    two_word[10] = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00,
                                    8'h00, 8'h93, 8'h00, 8'h10, 8'h00};

    imem_loader #(.ADDR_WIDTH(AW)) dut (
        .SYS_clk     (SYS_clk),
        .SYS_reset_n (SYS_reset_n),
        .start       (start),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .cpu_hold    (cpu_hold),
        .done        (done),
        .error       (error),
        .word_count  (word_count)
    );

    always #5 SYS_clk = ~SYS_clk;

    always @(negedge SYS_clk) begin
        if (mem_we === 1'b1) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge SYS_clk);
        start = 1'b1;
        @(negedge SYS_clk);
        start = 1'b0;
    endtask

    // Presents one byte and returns just after the edge on which it was accepted.
    task automatic send_byte(input logic [7:0] b, input bit gap);
        int n = 0;
        if (gap) begin
            @(negedge SYS_clk);
            rx_valid = 1'b0;
        end
        @(negedge SYS_clk);
        rx_data  = b;
        rx_valid = 1'b1;
        while (rx_ready !== 1'b1 && n < 50) begin
            @(negedge SYS_clk);
            n++;
        end
        if (rx_ready !== 1'b1) begin
            check("rx_ready_timeout", 32'(rx_ready), 32'd1);
            rx_valid = 1'b0;
        end else begin
            @(posedge SYS_clk);
        end
    endtask

    task automatic end_stream();
        @(negedge SYS_clk);
        rx_valid = 1'b0;
    endtask

    task automatic load_two(input bit gap, input logic [7:0] csum);
        pulse_start();
        for (int i = 0; i < 10; i++) send_byte(two_word[i], gap);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(csum, gap);
`else
        if (csum == 8'hFF) send_byte(csum, gap);
`endif
        end_stream();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rx_ready"},   32'(rx_ready),   32'd0);
        check({tag, "_mem_we"},     32'(mem_we),     32'd0);
        check({tag, "_mem_addr"},   32'(mem_addr),   32'd0);
        check({tag, "_mem_wdata"},  mem_wdata,       32'd0);
        check({tag, "_cpu_hold"},   32'(cpu_hold),   32'd1);
        check({tag, "_done"},       32'(done),       32'd0);
        check({tag, "_error"},      32'(error),      32'd0);
        check({tag, "_word_count"}, 32'(word_count), 32'd0);
    endtask

    task automatic check_two_word_writes(input string tag);
        @(negedge SYS_clk);
        #1;
        check({tag, "_nwrites"}, 32'(wr_addr_q.size()), 32'd2);
        check({tag, "_addr0"},   32'(wr_addr_q[0]),     32'd0);
        check({tag, "_data0"},   wr_data_q[0],          32'h0000_0013);
        check({tag, "_addr1"},   32'(wr_addr_q[1]),     32'd1);
        check({tag, "_data1"},   wr_data_q[1],          32'h0010_0093);
    endtask

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    initial begin
        // Reset state, then bytes offered in IDLE are refused.
        repeat (2) @(negedge SYS_clk);
        check_reset_values("rst");
        SYS_reset_n = 1'b1;
        @(negedge SYS_clk);
        rx_data  = 8'hAA;
        rx_valid = 1'b1;
        repeat (2) @(negedge SYS_clk);
        check("idle_rx_ready", 32'(rx_ready), 32'd0);
        check("idle_cpu_hold", 32'(cpu_hold), 32'd1);
        rx_valid = 1'b0;

        // Two-word load with valid held high.
        clear_log();
        load_two(1'b0, 8'h90);
        check("two_done",       32'(done),       32'd1);
        check("two_cpu_hold",   32'(cpu_hold),   32'd0);
        check("two_error",      32'(error),      32'd0);
        check("two_rx_ready",   32'(rx_ready),   32'd0);
        check("two_word_count", 32'(word_count), 32'd2);
`ifndef IMEM_LOADER_CHECKSUM_EN
        check("two_last_we",    32'(mem_we),     32'd1);
        check("two_last_addr",  32'(mem_addr),   32'd1);
        check("two_last_data",  mem_wdata,       32'h0010_0093);
`endif
        check_two_word_writes("two");

        // Zero length.
        clear_log();
        pulse_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h00, 1'b0);
`endif
        end_stream();
        check("zero_done",       32'(done),       32'd1);
        check("zero_error",      32'(error),      32'd0);
        check("zero_word_count", 32'(word_count), 32'd0);
        @(negedge SYS_clk);
        check("zero_nwrites", 32'(wr_addr_q.size()), 32'd0);

        // Overlength 1025 words.
        clear_log();
        pulse_start();
        send_byte(8'h01, 1'b0);
        send_byte(8'h04, 1'b0);
        end_stream();
        check("over_error",    32'(error),    32'd1);
        check("over_done",     32'(done),     32'd0);
        check("over_rx_ready", 32'(rx_ready), 32'd0);
        check("over_cpu_hold", 32'(cpu_hold), 32'd1);
        rx_data  = 8'h55;
        rx_valid = 1'b1;
        repeat (2) @(negedge SYS_clk);
        rx_valid = 1'b0;
        check("over_hold_error", 32'(error), 32'd1);
        check("over_nwrites", 32'(wr_addr_q.size()), 32'd0);

        // Same two-word load with rx_valid gapped every other cycle.
        clear_log();
        load_two(1'b1, 8'h90);
        check("gap_done",       32'(done),       32'd1);
        check("gap_cpu_hold",   32'(cpu_hold),   32'd0);
        check("gap_word_count", 32'(word_count), 32'd2);
        check_two_word_writes("gap");

        // Reset after six payload bytes: first word kept, then a fresh session.
        clear_log();
        pulse_start();
        for (int i = 0; i < 8; i++) send_byte(two_word[i], 1'b0);
        @(negedge SYS_clk);
        rx_valid    = 1'b0;
        SYS_reset_n = 1'b0;
        #1;
        check_reset_values("midrst");
        @(negedge SYS_clk);
        SYS_reset_n = 1'b1;
        repeat (3) @(negedge SYS_clk);
        check("midrst_nwrites", 32'(wr_addr_q.size()), 32'd1);
        check("midrst_addr0",   32'(wr_addr_q[0]),     32'd0);
        check("midrst_data0",   wr_data_q[0],          32'h0000_0013);
        clear_log();
        load_two(1'b0, 8'h90);
        check("reload_done",       32'(done),       32'd1);
        check("reload_word_count", 32'(word_count), 32'd2);
        check_two_word_writes("reload");

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Wrong checksum: words land but the core stays held.
        clear_log();
        load_two(1'b0, 8'h81);
        check("bad_csum_error",    32'(error),    32'd1);
        check("bad_csum_done",     32'(done),     32'd0);
        check("bad_csum_cpu_hold", 32'(cpu_hold), 32'd1);
        check_two_word_writes("bad_csum");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
